fft_seq_ctrl: RTL and testbench
===============================

// Module: fft_seq_ctrl
// PURPOSE
//   Sequencer for the in-place radix-2 DIT FFT built around regfile_fft and a pipelined butterfly.
//   Runs log2(N) stages of N/2 butterflies, one butterfly issued per cycle.
//   Per butterfly it drives regfile read addresses, twiddle index and stage number.
//   It drives write-backs delayed by the butterfly latency, plus start/busy/done to the top.
//   Input must already be loaded in bit-reversed order; the result is left in natural order.
// PARAMETERS
//   N       8  FFT size; power of two, N >= 4
//   BF_LAT  1  cycles from butterfly issue (read) to write-back data valid; BF_LAT >= 1
// PORTS
//   clk       in   1               clock
//   rst       in   1               asynchronous reset, active-high
//   start     in   1               request FFT run; sampled only in IDLE
//   busy      out  1               high while a run is in progress
//   done      out  1               one-cycle pulse after final write-back
//   rd_valid  out  1               butterfly issued this cycle (raddr/tw_idx valid)
//   raddr1    out  $clog2(N)       top butterfly operand address
//   raddr2    out  $clog2(N)       bottom operand address (raddr1 + half)
//   tw_idx    out  $clog2(N)-1     twiddle k in W_N^k, k = 0..N/2-1
//   stage     out  $clog2(N)       current issue stage (for per-stage scaling)
//   we1, we2  out  1               write enables, always asserted together
//   waddr1    out  $clog2(N)       raddr1 delayed BF_LAT cycles
//   waddr2    out  $clog2(N)       raddr2 delayed BF_LAT cycles
// BEHAVIOUR
//   Reset: state=IDLE; every output 0; address/we delay pipeline cleared.
//   FSM states: IDLE, RUN, DRAIN.
//   IDLE -> RUN: on an edge with start=1. Stage 0, butterfly 0 is issued in the next cycle.
//   RUN: one butterfly per cycle, b = 0..N/2-1, with rd_valid=1.
//     - Addressing (LOGN = $clog2(N), s = stage): half = 1<<s; grp = b>>s; pos = b & (half-1).
//     - raddr1 = grp*2*half + pos; raddr2 = raddr1 + half; tw_idx = pos << (LOGN-1-s).
//     - After b = N/2-1 issues: go to DRAIN.
//   DRAIN: BF_LAT cycles with rd_valid=0; raddr1/raddr2/tw_idx = 0; stage held.
//     - Exit to RUN with stage+1 and b=0 if s < LOGN-1; otherwise exit to IDLE.
//     - Guarantees that the first read of stage s+1 follows the last write of stage s (RAW-safe through the combinational regfile).
//   Write-back: we1/we2/waddr1/waddr2 equal rd_valid/raddr1/raddr2 delayed exactly BF_LAT cycles via a shift register.
//     - we is high in the cycle the butterfly result is presented; the regfile captures it at the end of that cycle.
//   busy: 1 in every RUN/DRAIN cycle; 0 in IDLE.
//   Latency: busy lasts LOGN*(N/2+BF_LAT) cycles (N=8, BF_LAT=1: 15).
//   done: pulses in the first IDLE cycle after the final DRAIN. The next start may be sampled in that same cycle.
//   start while busy: ignored; no queuing.
//   Reset mid-run: immediate return to IDLE. Pending we in the delay line are cleared, so no further writes occur.
//     - done is not pulsed; regfile contents are undefined (regfile resets too).
//   The top must keep regfile load=0 while busy; the controller does not gate load.
//   All counters are unsigned with no wrap: b ends at N/2-1, stage ends at LOGN-1.
// TESTING
//   1. N=8, BF_LAT=1, start pulse -> stage0 pairs (0,1)(2,3)(4,5)(6,7), all tw 0.
//      stage1 pairs (0,2)t0 (1,3)t2 (4,6)t0 (5,7)t2.
//      stage2 pairs (0,4)t0 (1,5)t1 (2,6)t2 (3,7)t3.
//   2. Same run -> busy high exactly 15 cycles; done one-cycle pulse in cycle 16; we/waddr trail rd_valid/raddr by 1 cycle.
//   3. BF_LAT=3, N=8 -> busy 21 cycles; 3 rd_valid=0 cycles between stages; last we coincides with last busy cycle.
//   4. Full FFT with regfile and butterfly: impulse x[0]=1.0 (0x100, bit-reversed load) -> all X[k]=0x100 re, 0 im.
//      DC x[n]=0.125 -> X[0]=1.0, others 0 (±1 LSB).
//   5. Assert start in cycles 3..10 of a run -> ignored, timing unchanged.
//      start held high through done -> new run begins the cycle after done.
//   6. rst asserted mid-stage1 -> next edge: busy=0, we=0, all addresses 0, no done.
//      A subsequent start runs a full normal sequence.

Source files
------------

// File: rtl/fft_seq_ctrl.sv
// fft_seq_ctrl
//   Sequencer for an in-place radix-2 DIT FFT built around a combinational
//   register file and a pipelined butterfly unit.
//   It runs log2(N) stages. Each stage issues N/2 butterflies, one per cycle.
//   After each stage it holds for BF_LAT cycles, so that every write-back of
//   that stage lands before the next stage reads.
//   The input must already be stored in bit-reversed order. The result is
//   left in natural order.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start           run request, sampled only while idle
//   busy            high for every cycle of a run
//   done            one-cycle pulse in the first idle cycle after a run
//   rd_valid        a butterfly is issued this cycle
//   raddr1, raddr2  top and bottom operand read addresses
//   tw_idx          twiddle exponent k of W_N^k
//   stage           stage currently being issued
//   we1, we2        write enables (always equal)
//   waddr1, waddr2  write-back addresses (read addresses delayed BF_LAT cycles)

module fft_seq_ctrl #(
  parameter int N      = 8,
  parameter int BF_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_valid,
  output logic [$clog2(N)-1:0]   raddr1,
  output logic [$clog2(N)-1:0]   raddr2,
  output logic [$clog2(N)-2:0]   tw_idx,
  output logic [$clog2(N)-1:0]   stage,
  output logic                   we1,
  output logic                   we2,
  output logic [$clog2(N)-1:0]   waddr1,
  output logic [$clog2(N)-1:0]   waddr2
);

  localparam int LOGN = $clog2(N);
  localparam int AW   = LOGN;
  localparam int BW   = LOGN - 1;
  localparam int DCW  = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} stateType;

  stateType        state, stateNext;
  logic [BW-1:0]   bfly, bflyNext;
  logic [AW-1:0]   stageReg, stageNext;
  logic [DCW-1:0]  drainCnt, drainNext;
  logic            doneReg, doneNext;

  logic [AW-1:0]   bExt, half, pos, grp, addr1, addr2, twFull;

  logic [BF_LAT-1:0] weDly;
  logic [AW-1:0]     w1Dly [BF_LAT];
  logic [AW-1:0]     w2Dly [BF_LAT];

  // Control registers: FSM state, butterfly and stage counters, drain timer, done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bfly     <= '0;
      stageReg <= '0;
      drainCnt <= '0;
      doneReg  <= 1'b0;
    end else begin
      state    <= stateNext;
      bfly     <= bflyNext;
      stageReg <= stageNext;
      drainCnt <= drainNext;
      doneReg  <= doneNext;
    end
  end

  // Butterfly addressing for stage s: half = 2^s. The group index is shifted
  // up by s+1 and the position inside the group is added. The twiddle
  // exponent is the position scaled up to the N-point twiddle table.
  always_comb begin
    bExt   = {1'b0, bfly};
    half   = AW'(1) << stageReg;
    pos    = bExt & (half - AW'(1));
    grp    = bExt >> stageReg;
    addr1  = ((grp << stageReg) << 1) | pos;
    addr2  = addr1 + half;
    twFull = pos << (AW'(LOGN - 1) - stageReg);
  end

  // Next-state logic and issue-side outputs
  always_comb begin
    stateNext = state;
    bflyNext  = bfly;
    stageNext = stageReg;
    drainNext = drainCnt;
    doneNext  = 1'b0;
    rd_valid  = 1'b0;
    raddr1    = '0;
    raddr2    = '0;
    tw_idx    = '0;
    busy      = 1'b0;
    stage     = stageReg;
    done      = doneReg;

    case (state)
      IDLE: begin
        if (start) begin
          stateNext = RUN;
          bflyNext  = '0;
          stageNext = '0;
        end
      end
      RUN: begin
        busy     = 1'b1;
        rd_valid = 1'b1;
        raddr1   = addr1;
        raddr2   = addr2;
        tw_idx   = twFull[BW-1:0];
        if (bfly == BW'(N/2 - 1)) begin
          stateNext = DRAIN;
          drainNext = '0;
        end else begin
          bflyNext = bfly + BW'(1);
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (drainCnt == DCW'(BF_LAT - 1)) begin
          if (stageReg == AW'(LOGN - 1)) begin
            stateNext = IDLE;
            stageNext = '0;
            doneNext  = 1'b1;
          end else begin
            stateNext = RUN;
            stageNext = stageReg + AW'(1);
            bflyNext  = '0;
          end
        end else begin
          drainNext = drainCnt + DCW'(1);
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Write-back delay line. Reset flushes any pending writes, so a run
  // aborted by reset stops writing immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) begin
        weDly[i] <= 1'b0;
        w1Dly[i] <= '0;
        w2Dly[i] <= '0;
      end
    end else begin
      weDly[0] <= rd_valid;
      w1Dly[0] <= raddr1;
      w2Dly[0] <= raddr2;
      for (int i = 1; i < BF_LAT; i++) begin
        weDly[i] <= weDly[i-1];
        w1Dly[i] <= w1Dly[i-1];
        w2Dly[i] <= w2Dly[i-1];
      end
    end
  end

  always_comb begin
    we1    = weDly[BF_LAT-1];
    we2    = weDly[BF_LAT-1];
    waddr1 = w1Dly[BF_LAT-1];
    waddr2 = w2Dly[BF_LAT-1];
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// tb_fft_seq_ctrl
//   Drives two sequencers (N=8, BF_LAT=1 and BF_LAT=3) from one clock, each
//   with its own start and reset. Every cycle, both are compared against a
//   reference. The reference computes the outputs from the cycle count since
//   the run began, using plain arithmetic on stages and butterflies.

module tb_fft_seq_ctrl;

  localparam int N = 8;

  logic clk = 1'b0;
  logic start1, rst1, start3, rst3;

  logic       busy1, done1, rv1, we11, we21;
  logic [2:0] ra11, ra21, st1, wa11, wa21;
  logic [1:0] tw1;
  logic       busy3, done3, rv3, we13, we23;
  logic [2:0] ra13, ra23, st3, wa13, wa23;
  logic [1:0] tw3;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference state per instance: cycle index within the run (-1 when idle)
  // and whether done is expected this cycle.
  int   modelCyc  [2];
  logic modelDone [2];

  always #5 clk = ~clk;

  fft_seq_ctrl #(.N(N), .BF_LAT(1)) dut1 (
    .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
    .rd_valid(rv1), .raddr1(ra11), .raddr2(ra21), .tw_idx(tw1), .stage(st1),
    .we1(we11), .we2(we21), .waddr1(wa11), .waddr2(wa21)
  );

  fft_seq_ctrl #(.N(N), .BF_LAT(3)) dut3 (
    .clk(clk), .rst(rst3), .start(start3), .busy(busy3), .done(done3),
    .rd_valid(rv3), .raddr1(ra13), .raddr2(ra23), .tw_idx(tw3), .stage(st3),
    .we1(we13), .we2(we23), .waddr1(wa13), .waddr2(wa23)
  );

  // Operand pair and twiddle of butterfly b in stage s: {a1, a2, tw}
  function automatic logic [7:0] pairOf(int s, int b);
    int h, a1, a2, tw;
    h  = 1 << s;
    a1 = (b / h) * 2 * h + (b % h);
    a2 = a1 + h;
    tw = (b % h) * ((N / 2) / h);
    return {3'(a1), 3'(a2), 2'(tw)};
  endfunction

  // Expected output vector:
  // {busy, done, rd_valid, raddr1, raddr2, tw_idx, stage, we1, we2, waddr1, waddr2}
  function automatic logic [21:0] expOut(int lat, int c, logic dn);
    int period, s, r, c2;
    logic [7:0] rp, wp;
    logic rv, we;
    if (c < 0) return {1'b0, dn, 20'b0};
    period = N / 2 + lat;
    s  = c / period;
    r  = c % period;
    rv = (r < N / 2);
    rp = rv ? pairOf(s, r) : 8'h00;
    c2 = c - lat;
    we = 1'b0;
    wp = 8'h00;
    if (c2 >= 0 && (c2 % period) < N / 2) begin
      we = 1'b1;
      wp = pairOf(c2 / period, c2 % period);
    end
    return {1'b1, 1'b0, rv, rp, 3'(s), we, we, wp[7:2]};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic updateModel(int k, int lat, logic st, logic rs);
    int total;
    total = 3 * (N / 2 + lat);
    if (rs) begin
      modelCyc[k]  = -1;
      modelDone[k] = 1'b0;
    end else if (modelCyc[k] < 0) begin
      modelDone[k] = 1'b0;
      if (st) modelCyc[k] = 0;
    end else begin
      modelCyc[k]++;
      if (modelCyc[k] == total) begin
        modelCyc[k]  = -1;
        modelDone[k] = 1'b1;
      end
    end
  endtask

  task automatic compareBoth();
    checkOutput("dut1_outputs",
      32'({busy1, done1, rv1, ra11, ra21, tw1, st1, we11, we21, wa11, wa21}),
      32'(expOut(1, modelCyc[0], modelDone[0])));
    checkOutput("dut3_outputs",
      32'({busy3, done3, rv3, ra13, ra23, tw3, st3, we13, we23, wa13, wa23}),
      32'(expOut(3, modelCyc[1], modelDone[1])));
  endtask

  // Inputs change just after a falling edge. The reference advances at the
  // rising edge, and outputs are compared at the next falling edge.
  task automatic applyStimulus(input logic s1, input logic r1,
                               input logic s3, input logic r3);
    start1 = s1; rst1 = r1;
    start3 = s3; rst3 = r3;
    @(posedge clk);
    updateModel(0, 1, s1, r1);
    updateModel(1, 3, s3, r3);
    @(negedge clk);
    compareBoth();
  endtask

  initial begin
    int cnt1, cnt3, dn1, dn3;
    modelCyc[0] = -1;   modelCyc[1] = -1;
    modelDone[0] = 1'b0; modelDone[1] = 1'b0;
    start1 = 1'b0; start3 = 1'b0;
    rst1 = 1'b1;   rst3 = 1'b1;
    @(negedge clk);

    $display("[TB] reset");
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);

    $display("[TB] single run, busy length and done pulse");
    applyStimulus(1, 0, 1, 0);
    cnt1 = 0; cnt3 = 0; dn1 = 0; dn3 = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy1) cnt1++;
      if (busy3) cnt3++;
      if (done1) dn1++;
      if (done3) dn3++;
      applyStimulus(0, 0, 0, 0);
    end
    checkOutput("busy_len_lat1", 32'(cnt1), 32'd15);
    checkOutput("busy_len_lat3", 32'(cnt3), 32'd21);
    checkOutput("done_cnt_lat1", 32'(dn1), 32'd1);
    checkOutput("done_cnt_lat3", 32'(dn3), 32'd1);

    $display("[TB] start held high, back-to-back runs");
    for (int i = 0; i < 60; i++) applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 25; i++) applyStimulus(0, 0, 0, 0);

    $display("[TB] reset during stage 1");
    applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0);
    for (int i = 0; i < 25; i++) applyStimulus(0, 0, 0, 0);

    $display("[TB] random start/reset");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
